// File: rtl/ddr2_pkg.sv
// Shared constants, arbiter state encoding and round-robin pick helper for
// the DDR2 request arbiter.
package ddr2_pkg;

    localparam int ADDR_W  = 26;
    localparam int DATA_W  = 8;
    localparam int MAX_REQ = 8;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_t;

    // First set bit of elig at or after ptr (wrapping modulo n); -1 if none.
    function automatic int rr_pick(
        input logic [MAX_REQ-1:0] elig,
        input logic [31:0]        n,
        input logic [31:0]        ptr
    );
        int         result;
        logic [2:0] j;
        result = -1;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n && result < 0) begin
                j = 3'((ptr + k) % n);
                if (elig[j]) result = int'(j);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ddr2_tag_fifo.sv
// Read-tag FIFO: remembers which requester issued each outstanding read so
// returning data can be steered back in command order.
module ddr2_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ddr2_req_arbiter.sv
// Round-robin arbiter sharing the DDR2 user command port between NUM_REQ
// requesters, with a registered command stage and read-tag return steering.
// Optional ARB_BURST_LOCK_EN: a requester keeps the port until its req_last beat.
module ddr2_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = ddr2_pkg::ADDR_W,
    parameter int DATA_W         = ddr2_pkg::DATA_W,
    parameter int RD_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic                      mem_cmd_valid,
    input  logic                      mem_cmd_ready,
    output logic                      mem_cmd_write,
    output logic [ADDR_W-1:0]         mem_cmd_addr,
    output logic [DATA_W-1:0]         mem_cmd_wdata,
    input  logic                      mem_rd_valid,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_orphan
);

    import ddr2_pkg::*;

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(RD_OUTSTANDING) + 1;

    arb_state_t           state;
    logic [TAG_W-1:0]     owner;
    logic [TAG_W-1:0]     rr_ptr;
    logic [TAG_W-1:0]     rr_next;
    logic [TAG_W-1:0]     grant_idx;
    logic                 grant_found;
    logic                 cmd_free;
    logic                 fire;
    logic                 ends_own;
    logic [NUM_REQ-1:0]   elig;
    logic [MAX_REQ-1:0]   elig_pad;
    int                   pick;

    logic                 tag_push;
    logic                 tag_pop;
    logic [TAG_W-1:0]     tag_head;
    logic [CNT_W-1:0]     tag_count;
    logic                 tag_full;
    logic                 tag_empty;
    logic [NUM_REQ-1:0]   head_onehot;

`ifdef ARB_BURST_LOCK_EN
    assign ends_own = req_last[grant_idx];
`else
    logic unused_last;
    assign ends_own    = 1'b1;
    assign unused_last = ^req_last;
`endif

    assign fire     = |(req_valid & req_ready);
    assign tag_push = fire && !req_write[grant_idx];
    assign tag_pop  = mem_rd_valid && !tag_empty;
    assign rr_next  = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Eligibility, grant selection and the combinational ready.
    always_comb begin
        elig     = req_valid & (req_write | {NUM_REQ{!tag_full}});
        elig_pad = '0;
        elig_pad[NUM_REQ-1:0] = elig;
        pick     = rr_pick(elig_pad, 32'(NUM_REQ), 32'(rr_ptr));
        grant_found = 1'b0;
        grant_idx   = '0;
        if (state == OWN) begin
            grant_found = elig[owner];
            grant_idx   = owner;
        end else if (pick >= 0) begin
            grant_found = 1'b1;
            grant_idx   = pick[TAG_W-1:0];
        end
        cmd_free  = !mem_cmd_valid || mem_cmd_ready;
        req_ready = '0;
        if (grant_found && cmd_free) req_ready[grant_idx] = 1'b1;
    end

    // Ownership FSM and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ARB;
            owner  <= '0;
            rr_ptr <= '0;
        end else if (fire) begin
            if (ends_own) begin
                state  <= ARB;
                rr_ptr <= rr_next;
            end else begin
                state <= OWN;
                owner <= grant_idx;
            end
        end
    end

    // Registered command stage; held while the controller back-pressures.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_cmd_valid <= 1'b0;
            mem_cmd_write <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_wdata <= '0;
        end else if (fire) begin
            mem_cmd_valid <= 1'b1;
            mem_cmd_write <= req_write[grant_idx];
            mem_cmd_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            mem_cmd_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
        end else if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
        end
    end

    // One-hot decode of the oldest outstanding read's issuer.
    always_comb begin
        head_onehot = '0;
        head_onehot[tag_head] = 1'b1;
    end

    // Read return steering and orphan detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_orphan <= 1'b0;
        end else begin
            rsp_valid  <= tag_pop ? head_onehot : '0;
            rsp_orphan <= mem_rd_valid && tag_empty;
            if (tag_pop) rsp_data <= mem_rd_data;
        end
    end

    ddr2_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (RD_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tag_push),
        .push_data (grant_idx),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    logic unused_count;
    assign unused_count = ^tag_count;

endmodule

// File: tb/tb_ddr2_req_arbiter.sv
// Randomized bench for ddr2_req_arbiter against a queue-based reference model.
module tb_ddr2_req_arbiter;

    localparam int N   = 2;
    localparam int AW  = 26;
    localparam int DW  = 8;
    localparam int RDO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, req_write, req_last, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
    logic [AW-1:0]   mem_cmd_addr;
    logic [DW-1:0]   mem_cmd_wdata, mem_rd_data, rsp_data;
    logic            mem_rd_valid, rsp_orphan;

    always #5 clk = ~clk;

    ddr2_req_arbiter #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .RD_OUTSTANDING (RDO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_last      (req_last),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_write (mem_cmd_write),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_wdata (mem_cmd_wdata),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_data   (mem_rd_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_orphan    (rsp_orphan)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int            m_rr, m_owner;
    bit            m_own;
    int            tagq[$];
    logic          m_cv, m_cw;
    logic [AW-1:0] m_ca;
    logic [DW-1:0] m_cd;
    logic [N-1:0]  m_rv;
    logic [DW-1:0] m_rd;
    logic          m_orph;

    // Pending stimulus, applied just after a rising edge
    logic [N-1:0]    p_valid, p_write, p_last;
    logic [N*AW-1:0] p_addr;
    logic [N*DW-1:0] p_wdata;
    logic            p_mready, p_rdv;
    logic [DW-1:0]   p_rdd;

    task automatic model_reset();
        m_rr = 0; m_owner = 0; m_own = 0;
        tagq.delete();
        m_cv = 0; m_cw = 0; m_ca = '0; m_cd = '0;
        m_rv = '0; m_rd = '0; m_orph = 0;
    endtask

    task automatic set_idle();
        p_valid = '0; p_write = '0; p_last = '1;
        p_addr = '0; p_wdata = '0;
        p_mready = 1'b1; p_rdv = 1'b0; p_rdd = '0;
    endtask

    task automatic set_random(input int pv, input int pr, input int pm, input int prd);
        for (int i = 0; i < N; i++) begin
            p_valid[i] = ($urandom_range(99) < pv);
            p_write[i] = ($urandom_range(99) >= pr);
            p_last[i]  = $urandom_range(1);
            p_addr[i*AW +: AW]  = AW'($urandom);
            p_wdata[i*DW +: DW] = DW'($urandom);
        end
        p_mready = ($urandom_range(99) < pm);
        p_rdv    = ($urandom_range(99) < prd);
        p_rdd    = DW'($urandom);
    endtask

    task automatic apply_pend();
        req_valid = p_valid; req_write = p_write; req_last = p_last;
        req_addr = p_addr; req_wdata = p_wdata;
        mem_cmd_ready = p_mready; mem_rd_valid = p_rdv; mem_rd_data = p_rdd;
    endtask

    task automatic check_regs();
        check("mem_cmd_valid", mem_cmd_valid, m_cv);
        check("mem_cmd_write", mem_cmd_write, m_cw);
        check("mem_cmd_addr",  mem_cmd_addr,  m_ca);
        check("mem_cmd_wdata", mem_cmd_wdata, m_cd);
        check("rsp_valid",     rsp_valid,     m_rv);
        check("rsp_data",      rsp_data,      m_rd);
        check("rsp_orphan",    rsp_orphan,    m_orph);
    endtask

    // Applies the rules to the current inputs: checks ready, then advances the model.
    task automatic model_step();
        bit           free, full, ok;
        int           g, h;
        logic [N-1:0] exp_ready;
        free = !m_cv || mem_cmd_ready;
        full = (tagq.size() >= RDO);
        g = -1;
        if (m_own) begin
            if (req_valid[m_owner] && (req_write[m_owner] || !full)) g = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                ok = req_valid[(m_rr + k) % N] && (req_write[(m_rr + k) % N] || !full);
                if (g < 0 && ok) g = (m_rr + k) % N;
            end
        end
        exp_ready = '0;
        if (g >= 0 && free) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);

        m_rv = '0; m_orph = 0;
        if (mem_rd_valid) begin
            if (tagq.size() > 0) begin
                h = tagq.pop_front();
                m_rv[h] = 1'b1;
                m_rd = mem_rd_data;
            end else begin
                m_orph = 1;
            end
        end

        if (exp_ready != '0) begin
            if (!req_write[g]) tagq.push_back(g);
            m_cv = 1; m_cw = req_write[g];
            m_ca = req_addr[g*AW +: AW];
            m_cd = req_wdata[g*DW +: DW];
`ifdef ARB_BURST_LOCK_EN
            if (req_last[g]) begin
                m_own = 0; m_rr = (g + 1) % N;
            end else begin
                m_own = 1; m_owner = g;
            end
`else
            m_rr = (g + 1) % N;
`endif
        end else if (mem_cmd_ready) begin
            m_cv = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        check_regs();
        apply_pend();
        #1;
        model_step();
    endtask

    task automatic async_reset();
        #1;
        reset = 1'b1;
        req_valid = '0;
        #1;
        check("rst_cmd_valid", mem_cmd_valid, 1'b0);
        check("rst_cmd_write", mem_cmd_write, 1'b0);
        check("rst_cmd_addr",  mem_cmd_addr,  '0);
        check("rst_cmd_wdata", mem_cmd_wdata, '0);
        check("rst_rsp_valid", rsp_valid,     '0);
        check("rst_rsp_data",  rsp_data,      '0);
        check("rst_orphan",    rsp_orphan,    1'b0);
        check("rst_req_ready", req_ready,     '0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        check_regs();
        set_idle();
        apply_pend();
        #1;
        model_step();
    endtask

    int ph_pv[8]  = '{90, 80, 90, 60, 90, 50, 100, 70};
    int ph_pr[8]  = '{ 0, 50, 90, 80, 100, 50, 50, 30};
    int ph_pm[8]  = '{100, 70, 80, 30, 100, 50, 20, 90};
    int ph_prd[8] = '{ 0, 30,  5, 50,  0, 90, 40, 60};

    initial begin
        reset = 1'b1;
        set_idle();
        apply_pend();
        model_reset();
        #2;
        check_regs();
        check("rst_req_ready", req_ready, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        model_step();

        // Two reads from different requesters, data returned in order
        set_idle(); p_valid = 2'b10; p_write = 2'b00; p_addr[AW +: AW] = 26'h10; cycle();
        set_idle(); p_valid = 2'b01; p_write = 2'b00; p_addr[0 +: AW] = 26'h20; cycle();
        set_idle(); cycle();
        set_idle(); p_rdv = 1'b1; p_rdd = 8'hA5; cycle();
        set_idle(); p_rdv = 1'b1; p_rdd = 8'h3C; cycle();
        check("dir_rsp0_valid", rsp_valid, 2'b10);
        check("dir_rsp0_data",  rsp_data,  8'hA5);
        set_idle(); cycle();
        check("dir_rsp1_valid", rsp_valid, 2'b01);
        check("dir_rsp1_data",  rsp_data,  8'h3C);

        // Return with nothing outstanding
        set_idle(); p_rdv = 1'b1; cycle();
        set_idle(); cycle();
        check("dir_orphan",       rsp_orphan, 1'b1);
        check("dir_orphan_rsp_v", rsp_valid,  '0);

        // Fill the tag FIFO from requester 0, then probe the ninth read
        async_reset();
        for (int i = 0; i < RDO; i++) begin
            set_idle(); p_valid = 2'b01; p_write = 2'b00; p_addr[0 +: AW] = AW'(i); cycle();
        end
        set_idle(); p_valid = 2'b11; p_write = 2'b10; cycle();
        check("full_rd_stall", req_ready, 2'b10);
        set_idle(); p_valid = 2'b01; p_write = 2'b00; p_rdv = 1'b1; cycle();
        check("full_same_pop", req_ready, 2'b00);
        set_idle(); p_valid = 2'b01; p_write = 2'b00; cycle();
        check("full_after_pop", req_ready, 2'b01);
        for (int i = 0; i < RDO; i++) begin
            set_idle(); p_rdv = 1'b1; p_rdd = DW'(i); cycle();
        end

`ifdef ARB_BURST_LOCK_EN
        // Burst lock: requester 1 waits for requester 0's last beat
        async_reset();
        for (int b = 0; b < 4; b++) begin
            set_idle(); p_valid = 2'b11; p_write = 2'b11; p_last = (b == 3) ? 2'b11 : 2'b10; cycle();
            check("burst_own", req_ready, 2'b01);
        end
        set_idle(); p_valid = 2'b11; p_write = 2'b11; cycle();
        check("burst_handover", req_ready, 2'b10);
`endif

        for (int ph = 0; ph < 8; ph++) begin
            for (int c = 0; c < 250; c++) begin
                set_random(ph_pv[ph], ph_pr[ph], ph_pm[ph], ph_prd[ph]);
                cycle();
                if (ph == 3 && c == 120) async_reset();
            end
        end

        set_idle();
        cycle();
        cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
